// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one external memory refill/writeback port between NUM_REQ core-side
// requesters (icache refill, dcache refill/writeback, page-table walker).
// A round-robin arbiter picks one requester, the burst sequencer then owns the
// memory port for the whole BEATS-beat burst, and on the final beat priority
// rotates so the requester that just finished becomes lowest priority.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// clk_i edge where both valid and ready are high. Valid is held, with its
// payload stable, until that happens. Ready may depend combinationally on
// valid. mem_rvalid_i is the only exception: it has no ready and must be taken.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester burst request; ready is a one-hot pulse
//   req_addr_i, req_write_i    per-requester base address (slice i) and direction
//   wdata_valid_i/wdata_i      per-requester write beats
//   wdata_ready_o              write beat accepted (owner only)
//   rdata_valid_o              read beat to the owner
//   rdata_o, rdata_last_o      shared read data, final-beat marker
//   mem_req_*                  memory address phase (latched address and direction)
//   mem_w*                     memory write-data channel
//   mem_rvalid_i, mem_rdata_i  memory read-data channel
//   grant_o                    one-hot current owner, 0 while idle
//   busy_o                     sequencer is not idle
module mem_port_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 56,
   parameter int DATA_W  = 64,
   parameter int BEATS   = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ-1:0]          req_write_i,
   input  logic [NUM_REQ-1:0]          wdata_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
   output logic [NUM_REQ-1:0]          wdata_ready_o,
   output logic [NUM_REQ-1:0]          rdata_valid_o,
   output logic [DATA_W-1:0]           rdata_o,
   output logic                        rdata_last_o,
   output logic                        mem_req_valid_o,
   input  logic                        mem_req_ready_i,
   output logic [ADDR_W-1:0]           mem_req_addr_o,
   output logic                        mem_req_write_o,
   output logic                        mem_wvalid_o,
   input  logic                        mem_wready_i,
   output logic [DATA_W-1:0]           mem_wdata_o,
   output logic                        mem_wlast_o,
   input  logic                        mem_rvalid_i,
   input  logic [DATA_W-1:0]           mem_rdata_i,
   output logic [NUM_REQ-1:0]          grant_o,
   output logic                        busy_o
);

   localparam int CNT_W = $clog2(BEATS);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      WDATA = 2'd2,
      RDATA = 2'd3
   } state_t;

   // state_q is the FSM state; busy_o mirrors (state_q != IDLE).
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;     // current owner
   logic [IDX_W-1:0]   ptr_q, ptr_d;     // last requester to complete a burst
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               write_q, write_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Per-requester views of the flattened address and write-data buses.
   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = wdata_i[i*DATA_W +: DATA_W];
   end

   // Round-robin pick: first requester above the pointer wins; if none,
   // the first one at or below it. This equals an upward search from
   // pointer+1 with wrap-around, without any modulo arithmetic.
   logic               hi_valid, lo_valid, pick_valid;
   logic [IDX_W-1:0]   hi_idx, lo_idx, pick_idx;

   always_comb begin
      hi_valid = 1'b0;
      hi_idx   = '0;
      lo_valid = 1'b0;
      lo_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!hi_valid && req_valid_i[i] && (IDX_W'(i) > ptr_q)) begin
            hi_valid = 1'b1;
            hi_idx   = IDX_W'(i);
         end
         if (!lo_valid && req_valid_i[i] && (IDX_W'(i) <= ptr_q)) begin
            lo_valid = 1'b1;
            lo_idx   = IDX_W'(i);
         end
      end
      pick_valid = hi_valid || lo_valid;
      pick_idx   = hi_valid ? hi_idx : lo_idx;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= PTR_RESET;
         addr_q  <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      ptr_d           = ptr_q;
      addr_d          = addr_q;
      write_d         = write_q;
      cnt_d           = cnt_q;
      req_ready_o     = '0;
      wdata_ready_o   = '0;
      rdata_valid_o   = '0;
      rdata_o         = '0;
      rdata_last_o    = 1'b0;
      mem_req_valid_o = 1'b0;
      mem_wvalid_o    = 1'b0;
      mem_wdata_o     = '0;
      mem_wlast_o     = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               req_ready_o[pick_idx] = 1'b1;
               idx_d                 = pick_idx;
               addr_d                = addr_arr[pick_idx];
               write_d               = req_write_i[pick_idx];
               state_d               = ADDR;
            end
         end

         ADDR: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) begin
               cnt_d   = '0;
               state_d = write_q ? WDATA : RDATA;
            end
         end

         WDATA: begin
            mem_wvalid_o         = wdata_valid_i[idx_q];
            mem_wdata_o          = wdata_arr[idx_q];
            wdata_ready_o[idx_q] = mem_wready_i;
            mem_wlast_o          = (cnt_q == LAST_BEAT);
            if (mem_wvalid_o && mem_wready_i) begin
               cnt_d = cnt_q + 1'b1;   // wraps to 0 on the last beat
               if (cnt_q == LAST_BEAT) begin
                  ptr_d   = idx_q;
                  state_d = IDLE;
               end
            end
         end

         RDATA: begin
            rdata_valid_o[idx_q] = mem_rvalid_i;
            rdata_o              = mem_rdata_i;
            rdata_last_o         = mem_rvalid_i && (cnt_q == LAST_BEAT);
            if (mem_rvalid_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  ptr_d   = idx_q;
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_o = '0;
      if (state_q != IDLE) begin
         grant_o[idx_q] = 1'b1;
      end
   end

   assign busy_o          = (state_q != IDLE);
   assign mem_req_addr_o  = addr_q;
   assign mem_req_write_o = write_q;

   // Read beats have no backpressure, so one arriving when no read burst is
   // open would be silently lost.
   rvalid_only_in_rdata: assert property (
      @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (state_q == RDATA)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int NR = 3;
   localparam int AW = 56;
   localparam int DW = 64;
   localparam int NB = 8;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready_o;
   logic [NR*AW-1:0]  req_addr;
   logic [NR-1:0]     req_write;
   logic [NR-1:0]     wdata_valid;
   logic [NR*DW-1:0]  wdata;
   logic [NR-1:0]     wdata_ready_o;
   logic [NR-1:0]     rdata_valid_o;
   logic [DW-1:0]     rdata_o;
   logic              rdata_last_o;
   logic              mem_req_valid_o;
   logic              mem_req_ready;
   logic [AW-1:0]     mem_req_addr_o;
   logic              mem_req_write_o;
   logic              mem_wvalid_o;
   logic              mem_wready;
   logic [DW-1:0]     mem_wdata_o;
   logic              mem_wlast_o;
   logic              mem_rvalid;
   logic [DW-1:0]     mem_rdata;
   logic [NR-1:0]     grant_o;
   logic              busy_o;

   int tests_run = 0;
   int tests_failed = 0;

   // Scoreboard queues: grant order, read beats {last, valid vector, data},
   // write beats {last, data}.
   logic [NR-1:0]     gnt_q [$];
   logic [DW+NR:0]    exp_q [$];
   logic [DW:0]       wr_q  [$];

   mem_port_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BEATS(NB)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr),
      .req_write_i     (req_write),
      .wdata_valid_i   (wdata_valid),
      .wdata_i         (wdata),
      .wdata_ready_o   (wdata_ready_o),
      .rdata_valid_o   (rdata_valid_o),
      .rdata_o         (rdata_o),
      .rdata_last_o    (rdata_last_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_write_o (mem_req_write_o),
      .mem_wvalid_o    (mem_wvalid_o),
      .mem_wready_i    (mem_wready),
      .mem_wdata_o     (mem_wdata_o),
      .mem_wlast_o     (mem_wlast_o),
      .mem_rvalid_i    (mem_rvalid),
      .mem_rdata_i     (mem_rdata),
      .grant_o         (grant_o),
      .busy_o          (busy_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int g);
      logic [NR-1:0] v;
      v = '0;
      v[g] = 1'b1;
      return v;
   endfunction

   // Monitor: compares DUT outputs against the expected queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_ready_o != '0) begin
            if (gnt_q.size() == 0) check("unexpected_ready", req_ready_o, '0);
            else check("grant_order", req_ready_o, gnt_q.pop_front());
         end
         if (rdata_valid_o != '0) begin
            if (exp_q.size() == 0) check("unexpected_rbeat", rdata_valid_o, '0);
            else check("rd_beat", {rdata_last_o, rdata_valid_o, rdata_o}, exp_q.pop_front());
         end
         if (mem_wvalid_o && mem_wready) begin
            if (wr_q.size() == 0) check("unexpected_wbeat", mem_wvalid_o, 1'b0);
            else check("wr_beat", {mem_wlast_o, mem_wdata_o}, wr_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n         = 1'b0;
      req_valid     = '0;
      wdata_valid   = '0;
      mem_req_ready = 1'b0;
      mem_wready    = 1'b0;
      mem_rvalid    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_req(input int g, input logic [AW-1:0] a, input logic w);
      req_valid[g]           = 1'b1;
      req_addr[g*AW +: AW]   = a;
      req_write[g]           = w;
   endtask

   task automatic check_quiet(input string pre);
      check({pre, "_busy"},      busy_o,          1'b0);
      check({pre, "_grant"},     grant_o,         '0);
      check({pre, "_req_ready"}, req_ready_o,     '0);
      check({pre, "_memreq"},    mem_req_valid_o, 1'b0);
      check({pre, "_addr"},      mem_req_addr_o,  '0);
      check({pre, "_wvalid"},    mem_wvalid_o,    1'b0);
      check({pre, "_wlast"},     mem_wlast_o,     1'b0);
      check({pre, "_rvalid"},    rdata_valid_o,   '0);
      check({pre, "_rlast"},     rdata_last_o,    1'b0);
      check({pre, "_wready"},    wdata_ready_o,   '0);
   endtask

   // Entered one step after the edge that moved the DUT into ADDR.
   task automatic addr_phase(input logic [AW-1:0] a, input logic w, input int stall, input int g);
      mem_req_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("addr_stall_valid", mem_req_valid_o, 1'b1);
         check("addr_stall_addr",  mem_req_addr_o,  a);
         check("addr_stall_noready", req_ready_o, '0);
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      check("addr_valid", mem_req_valid_o, 1'b1);
      check("addr_addr",  mem_req_addr_o,  a);
      check("addr_write", mem_req_write_o, w);
      check("addr_grant", grant_o, onehot(g));
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
   endtask

   task automatic read_burst(input int g, input bit gaps, input int nbeats);
      logic [DW-1:0] d;
      for (int i = 0; i < nbeats; i++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            mem_rvalid = 1'b0;
            @(negedge clk);
            check("rd_gap_quiet", rdata_valid_o, '0);
            @(posedge clk); #1;
         end
         d          = {$urandom, $urandom};
         mem_rvalid = 1'b1;
         mem_rdata  = d;
         exp_q.push_back({(i == NB - 1), onehot(g), d});
         @(negedge clk);
         check("rd_grant", grant_o, onehot(g));
         check("rd_no_ready", req_ready_o, '0);
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      check("rd_drained", exp_q.size(), 0);
   endtask

   task automatic write_burst(input int g, input logic [DW-1:0] base);
      int n;
      int cyc;
      for (int i = 0; i < NB; i++) wr_q.push_back({(i == NB - 1), base + DW'(i)});
      wdata_valid[g] = 1'b1;
      n   = 0;
      cyc = 0;
      while (n < NB && cyc < 4 * NB) begin
         mem_wready          = (cyc % 2 == 0);
         wdata[g*DW +: DW]   = base + DW'(n);
         @(negedge clk);
         check("wr_ready_mirror", wdata_ready_o, mem_wready ? onehot(g) : NR'(0));
         check("wr_valid", mem_wvalid_o, 1'b1);
         if (mem_wready) n++;
         @(posedge clk); #1;
         cyc++;
      end
      wdata_valid = '0;
      mem_wready  = 1'b0;
      check("wr_beats", n, NB);
      check("wr_drained", wr_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_addr = '0; req_write = '0;
      wdata_valid = '0; wdata = '0;
      mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      do_reset();
      @(negedge clk);
      check_quiet("reset");

      // Single read from requester 1.
      @(posedge clk); #1;
      set_req(1, 56'h8000_0040, 1'b0);
      gnt_q.push_back(3'b010);
      @(negedge clk);
      check("rd1_ready_c0", req_ready_o, 3'b010);
      check("rd1_idle_c0", busy_o, 1'b0);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      addr_phase(56'h8000_0040, 1'b0, 0, 1);
      read_burst(1, 1'b0, NB);
      @(negedge clk);
      check("rd1_busy_after", busy_o, 1'b0);
      check("rd1_grant_after", grant_o, '0);

      // Round-robin fairness with every requester valid continuously.
      do_reset();
      @(posedge clk); #1;
      for (int g = 0; g < NR; g++) set_req(g, AW'(32'h1000 * (g + 1)), 1'b0);
      for (int b = 0; b < 12; b++) begin
         gnt_q.push_back(onehot(b % NR));
         @(negedge clk);
         check("rr_idle_gap", busy_o, 1'b0);
         @(posedge clk); #1;
         addr_phase(AW'(32'h1000 * ((b % NR) + 1)), 1'b0, 0, b % NR);
         read_burst(b % NR, 1'b1, NB);
         if (b == 11) req_valid = '0;
      end
      check("rr_gnt_drained", gnt_q.size(), 0);

      // Write burst from requester 2 with mem_wready toggling.
      set_req(2, 56'h1000, 1'b1);
      gnt_q.push_back(3'b100);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      addr_phase(56'h1000, 1'b1, 0, 2);
      write_burst(2, 64'hA5A5_0000_0000_0000);
      @(negedge clk);
      check("wr_busy_after", busy_o, 1'b0);

      // Address stall; requester 0 arrives mid-burst and must wait.
      set_req(1, 56'h2000, 1'b0);
      gnt_q.push_back(3'b010);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      set_req(0, 56'h3000, 1'b0);
      addr_phase(56'h2000, 1'b0, 5, 1);
      gnt_q.push_back(3'b001);
      read_burst(1, 1'b0, NB);
      @(negedge clk);
      check("stall_late_ready", req_ready_o, 3'b001);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      addr_phase(56'h3000, 1'b0, 0, 0);
      read_burst(0, 1'b0, NB);

      // Reset after 3 read beats; pointer returns to NUM_REQ-1.
      set_req(1, 56'h4000, 1'b0);
      gnt_q.push_back(3'b010);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      addr_phase(56'h4000, 1'b0, 0, 1);
      read_burst(1, 1'b0, 3);
      rst_n = 1'b0;
      @(negedge clk);
      check_quiet("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 56'h4100, 1'b0);
      set_req(1, 56'h4200, 1'b0);
      gnt_q.push_back(3'b001);
      @(negedge clk);
      check("midrst_grant0", req_ready_o, 3'b001);
      @(posedge clk); #1;
      req_valid = '0;
      addr_phase(56'h4100, 1'b0, 0, 0);
      read_burst(0, 1'b0, NB);

      // Wrap: pointer = NUM_REQ-1, requesters 0 and 2 valid.
      do_reset();
      set_req(0, 56'h5000, 1'b0);
      set_req(2, 56'h7000, 1'b0);
      gnt_q.push_back(3'b001);
      @(negedge clk);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      addr_phase(56'h5000, 1'b0, 0, 0);
      gnt_q.push_back(3'b100);
      read_burst(0, 1'b0, NB);
      @(negedge clk);
      check("wrap_second", req_ready_o, 3'b100);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      addr_phase(56'h7000, 1'b0, 0, 2);
      read_burst(2, 1'b0, NB);
      @(negedge clk);
      check("wrap_done_busy", busy_o, 1'b0);

      check("end_gnt_q", gnt_q.size(), 0);
      check("end_exp_q", exp_q.size(), 0);
      check("end_wr_q",  wr_q.size(),  0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
